// File: rtl/serial_transmitter_32_w_if.sv
// Word-transmit handshake between a host and the 32-bit serial transmitter.
// The host drives data_in/start and observes busy, done and the serial line.
interface serial_transmitter_32_w_if;
    logic [31:0] data_in;
    logic        start;
    logic        busy;
    logic        done;
    logic        tx;

    modport master (
        output data_in,
        output start,
        input  busy,
        input  done,
        input  tx
    );

    modport slave (
        input  data_in,
        input  start,
        output busy,
        output done,
        output tx
    );
endinterface

// File: rtl/serial_transmitter_32_w.sv
// Sends a 32-bit word as four 8N1 bytes (LSB byte first), then holds the line
// high for a gap long enough to trip the receiver's idle timeout.
module serial_transmitter_32_w #(
    parameter int BIT_CYCLES = 4,
    parameter int GAP_CYCLES = 48
) (
    input  logic                        clk,
    input  logic                        rst_n,
    serial_transmitter_32_w_if.slave    bus
);
    localparam int             BW       = (BIT_CYCLES > 1) ? $clog2(BIT_CYCLES) : 1;
    localparam logic [BW-1:0]  BIT_LAST = BW'(BIT_CYCLES - 1);
    localparam logic [7:0]     GAP_LAST = 8'(GAP_CYCLES - 1);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        STOP,
        GAP
    } state_t;

    state_t         state_q;
    logic [31:0]    shift_q;
    logic [BW-1:0]  bit_cnt_q;
    logic [2:0]     bit_idx_q;
    logic [1:0]     byte_idx_q;
    logic [7:0]     gap_cnt_q;
    logic           tx_q;
    logic           busy_q;
    logic           done_q;

    logic [7:0]     cur_byte;
    logic [2:0]     next_bit;

    // The byte on the wire always sits in the low 8 bits of the shift register.
    assign cur_byte = shift_q[7:0];
    assign next_bit = bit_idx_q + 3'd1;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            shift_q    <= '0;
            bit_cnt_q  <= '0;
            bit_idx_q  <= '0;
            byte_idx_q <= '0;
            gap_cnt_q  <= '0;
            tx_q       <= 1'b1;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    tx_q <= 1'b1;
                    if (bus.start) begin
                        shift_q    <= bus.data_in;
                        byte_idx_q <= '0;
                        bit_cnt_q  <= '0;
                        tx_q       <= 1'b0;
                        busy_q     <= 1'b1;
                        state_q    <= START;
                    end
                end
                START: begin
                    if (bit_cnt_q == BIT_LAST) begin
                        bit_cnt_q <= '0;
                        bit_idx_q <= '0;
                        tx_q      <= cur_byte[0];
                        state_q   <= DATA;
                    end else begin
                        bit_cnt_q <= bit_cnt_q + 1'b1;
                    end
                end
                DATA: begin
                    if (bit_cnt_q == BIT_LAST) begin
                        bit_cnt_q <= '0;
                        if (bit_idx_q == 3'd7) begin
                            tx_q    <= 1'b1;
                            state_q <= STOP;
                        end else begin
                            bit_idx_q <= next_bit;
                            tx_q      <= cur_byte[next_bit];
                        end
                    end else begin
                        bit_cnt_q <= bit_cnt_q + 1'b1;
                    end
                end
                STOP: begin
                    if (bit_cnt_q == BIT_LAST) begin
                        bit_cnt_q <= '0;
                        if (byte_idx_q != 2'd3) begin
                            // Next start bit follows the stop bit with no idle.
                            byte_idx_q <= byte_idx_q + 2'd1;
                            shift_q    <= {8'h00, shift_q[31:8]};
                            tx_q       <= 1'b0;
                            state_q    <= START;
                        end else begin
                            gap_cnt_q <= '0;
                            state_q   <= GAP;
                        end
                    end else begin
                        bit_cnt_q <= bit_cnt_q + 1'b1;
                    end
                end
                GAP: begin
                    if (gap_cnt_q == GAP_LAST) begin
                        gap_cnt_q <= '0;
                        busy_q    <= 1'b0;
                        done_q    <= 1'b1;
                        state_q   <= IDLE;
                    end else begin
                        gap_cnt_q <= gap_cnt_q + 8'd1;
                    end
                end
                default: begin
                    tx_q    <= 1'b1;
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign bus.tx   = tx_q;
    assign bus.busy = busy_q;
    assign bus.done = done_q;
endmodule

// File: tb/tb_serial_transmitter_32_w.sv
// Directed bench for serial_transmitter_32_w: checks every clock of each frame
// against the expected 8N1 bit pattern, gap, done pulse and busy window.
module tb_serial_transmitter_32_w;
    logic clk;
    logic rst_n;
    int   n_compared;
    int   n_mismatched;

    serial_transmitter_32_w_if bus ();

    serial_transmitter_32_w #(
        .BIT_CYCLES (4),
        .GAP_CYCLES (48)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_compared++;
        assert (obs === exp) else begin
            n_mismatched++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Entered in cycle k+1 (just after the accepting edge k); returns in the
    // done cycle k+209, where next_word/next_start are applied for the next edge.
    task automatic frame(input logic [31:0] word, input logic [31:0] next_word,
                         input logic next_start, input logic poke);
        int  n;
        int  j;
        logic exp_tx;
        int  bad_tx;
        int  bad_busy;
        bad_tx   = 0;
        bad_busy = 0;
        for (int c = 0; c < 160; c++) begin
            n = c / 40;
            j = (c % 40) / 4;
            if (j == 0)      exp_tx = 1'b0;
            else if (j == 9) exp_tx = 1'b1;
            else             exp_tx = word[8*n + j - 1];
            if (bus.tx !== exp_tx) bad_tx++;
            if (bus.busy !== 1'b1 || bus.done !== 1'b0) bad_busy++;
            if (c == 49 || c == 149) begin
                bus.data_in = ~word;
                if (poke) bus.start = 1'b1;
            end
            if ((c == 50 || c == 150) && poke) bus.start = 1'b0;
            tick();
        end
        chk("frame_tx_bits_errors", 32'(bad_tx), 32'd0);
        chk("frame_busy_errors", 32'(bad_busy), 32'd0);
        bad_tx   = 0;
        bad_busy = 0;
        for (int g = 0; g < 48; g++) begin
            if (bus.tx !== 1'b1) bad_tx++;
            if (bus.busy !== 1'b1 || bus.done !== 1'b0) bad_busy++;
            tick();
        end
        chk("gap_tx_errors", 32'(bad_tx), 32'd0);
        chk("gap_busy_errors", 32'(bad_busy), 32'd0);
        chk("done_pulse", 32'(bus.done), 32'd1);
        chk("done_busy_low", 32'(bus.busy), 32'd0);
        chk("done_tx_idle", 32'(bus.tx), 32'd1);
        $display("frame word=%h checked, next_start=%0b", word, next_start);
        bus.data_in = next_word;
        bus.start   = next_start;
    endtask

    initial begin
        int bad;
        n_compared   = 0;
        n_mismatched = 0;
        rst_n        = 1'b0;
        bus.start    = 1'b0;
        bus.data_in  = 32'h0;

        // Reset held 5 cycles with a start pulse inside it.
        for (int i = 0; i < 5; i++) begin
            bus.start = (i == 2);
            bus.data_in = 32'h0000_0000;
            tick();
            chk("rst_tx", 32'(bus.tx), 32'd1);
            chk("rst_busy", 32'(bus.busy), 32'd0);
            chk("rst_done", 32'(bus.done), 32'd0);
        end
        bus.start = 1'b0;
        rst_n     = 1'b1;
        bad = 0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (bus.tx !== 1'b1 || bus.busy !== 1'b0 || bus.done !== 1'b0) bad++;
        end
        chk("post_rst_idle_errors", 32'(bad), 32'd0);
        $display("reset: idle after reset with start pulse inside reset");

        // Single word with ignored start pulses at k+50 and k+150.
        bus.data_in = 32'hA5C3_0F81;
        bus.start   = 1'b1;
        tick();
        bus.start = 1'b0;
        frame(32'hA5C3_0F81, 32'h0, 1'b0, 1'b1);
        tick();
        chk("after_done_cleared", 32'(bus.done), 32'd0);
        chk("after_done_idle_tx", 32'(bus.tx), 32'd1);

        // Edge-pattern words, each separated by idle time.
        bus.data_in = 32'h0000_0000; bus.start = 1'b1; tick(); bus.start = 1'b0;
        frame(32'h0000_0000, 32'h0, 1'b0, 1'b0);
        tick(); tick();
        bus.data_in = 32'hFFFF_FFFF; bus.start = 1'b1; tick(); bus.start = 1'b0;
        frame(32'hFFFF_FFFF, 32'h0, 1'b0, 1'b0);
        tick();
        bus.data_in = 32'h1234_5678; bus.start = 1'b1; tick(); bus.start = 1'b0;
        frame(32'h1234_5678, 32'h0, 1'b0, 1'b0);
        tick();

        // start held high: back-to-back words every 209 clocks.
        bus.data_in = 32'h0BAD_F00D; bus.start = 1'b1; tick();
        frame(32'h0BAD_F00D, 32'hDEAD_BEEF, 1'b1, 1'b0);
        tick();
        frame(32'hDEAD_BEEF, 32'h8001_7E42, 1'b1, 1'b0);
        tick();
        frame(32'h8001_7E42, 32'h0, 1'b0, 1'b0);
        tick();
        chk("held_end_idle_busy", 32'(bus.busy), 32'd0);

        // Reset mid byte 1 (edge k+70).
        bus.data_in = 32'h5A5A_C3C3; bus.start = 1'b1; tick(); bus.start = 1'b0;
        for (int i = 0; i < 69; i++) tick();
        chk("pre_abort_busy", 32'(bus.busy), 32'd1);
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        chk("abort_tx", 32'(bus.tx), 32'd1);
        chk("abort_busy", 32'(bus.busy), 32'd0);
        chk("abort_done", 32'(bus.done), 32'd0);
        bad = 0;
        for (int i = 0; i < 250; i++) begin
            tick();
            if (bus.tx !== 1'b1 || bus.busy !== 1'b0 || bus.done !== 1'b0) bad++;
        end
        chk("abort_quiet_errors", 32'(bad), 32'd0);
        $display("abort: line idle and no done after mid-frame reset");
        bus.data_in = 32'h3C96_E17B; bus.start = 1'b1; tick(); bus.start = 1'b0;
        frame(32'h3C96_E17B, 32'h0, 1'b0, 1'b0);
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end
endmodule

// File: doc/serial_transmitter_32_w.md
# serial_transmitter_32_w

Serial transmitter that sends one 32-bit word as four back-to-back UART-style bytes on a single line. Each byte is framed as 1 start bit, 8 data bits LSB first and 1 stop bit, with a fixed number of clocks per bit. After the last byte, the line is held idle-high for a frame gap long enough to trip the far-end receiver's idle timeout, which marks the word boundary. It sits on the FPGA side of the serial link, driving the line that the matching 32-bit word receiver samples.

## Interface
- BIT_CYCLES, 4 — clocks per bit; must stay 4 to match the receiver's bit strobe.
- GAP_CYCLES, 48 — idle-high clocks after the last stop bit; legal range 40..255; must exceed the receiver idle timeout (about 40 clocks of high line).
- clk  in  1  — system clock; all logic on rising edge.
- rst_n  in  1  — synchronous active-low reset.
- data_in  in  32  — word to send; sampled only on the accepting edge.
- start  in  1  — request; accepted on an edge where start=1 and busy=0.
- busy  out  1  — high while a frame (bytes + gap) is in progress.
- done  out  1  — one-cycle pulse when the frame, including the gap, completes.
- tx  out  1  — serial line, registered, idle high.

## Operation
- Reset (rst_n=0 at an edge): tx=1, busy=0, done=0, state IDLE, all counters 0, shift register 0.
- States: IDLE, START, DATA, STOP, GAP.
- IDLE:
  - tx=1.
  - When start=1 is seen: latch data_in into a 32-bit shift register, byte index=0, go to START, set busy=1.
- START: tx=0 for BIT_CYCLES clocks, then go to DATA with bit index=0.
- DATA:
  - tx = current byte bit[bit index], one bit per BIT_CYCLES clocks.
  - Bits are sent LSB first within the byte.
  - After bit 7, go to STOP.
- STOP:
  - tx=1 for BIT_CYCLES clocks.
  - If byte index < 3: increment it, select the next byte, and return to START with no extra idle.
  - Otherwise go to GAP.
- Byte order: data_in[7:0] first, then [15:8], [23:16], [31:24].
- GAP:
  - tx=1 for GAP_CYCLES clocks, then return to IDLE.
  - On that transition: busy=0 and done=1 for exactly one cycle.
- start is ignored while busy=1. A word presented then is dropped; no queuing.
- The accepting edge may coincide with the done cycle, since busy=0 there.
- Reset mid-frame: abort immediately. tx=1 from the next cycle, busy=0, no done pulse. The receiver discards the partial word through its timeout.
- Counters:
  - Bit-cycle counter wraps at BIT_CYCLES-1.
  - Bit index 3 bits, byte index 2 bits.
  - Gap counter 8 bits, counting 0..GAP_CYCLES-1.

## Timing
- start accepted at edge k. busy=1 and tx=0 (start bit) during cycles k+1..k+4.
- Byte n (n=0..3), data bit b: tx valid during cycles k+1+40n+4(b+1) .. +3.
- Byte n stop bit: cycles k+37+40n .. k+40+40n.
- Byte length 40 clocks; four bytes occupy cycles k+1..k+160.
- Gap: cycles k+161 .. k+160+GAP_CYCLES, which is k+208 at the default.
- done=1 and busy=0 in cycle k+161+GAP_CYCLES (k+209 at the default).
- Minimum word period: 161+GAP_CYCLES clocks (209 at the default).
- tx never glitches: every change happens on a clock edge, from a register.

## Test plan
- Reset behaviour: hold rst_n=0 for 5 cycles → tx=1, busy=0, done=0. Pulse start=1 during reset → nothing is sent.
- Single word: data_in=32'hA5C3_0F81, start pulsed once → byte sequence 0x81, 0x0F, 0xC3, 0xA5. Each byte is 0, then LSB..MSB, then 1, each bit exactly 4 clocks. Then 48 clocks high. done pulses at k+209.
- Loopback: feed tx into the 32-bit word receiver for words 32'h0000_0000, 32'hFFFF_FFFF, 32'h1234_5678 → receiver reports ready per byte with the correct bytes, and asserts timeout during each gap.
- Start held high continuously with data_in changing → a new word is accepted on each done cycle. Period is exactly 209 clocks, and data is latched only at acceptance.
- start pulsed at k+50 and k+150 with different data_in → ignored. Transmitted bytes still match the word latched at k.
- rst_n=0 at k+70 (mid byte 1) → tx=1 from k+71, busy=0, no done pulse. The next start sends a complete clean frame.
